aes_shift_rows_pipe: RTL and testbench
======================================

// Module: aes_shift_rows_pipe
// PURPOSE
// - Pipelined, multi-lane AES ShiftRows / InvShiftRows stage with valid/ready handshake.
// - Successor of the combinational ShiftRows: adds NumLanes parallel states, a registered elastic pipeline, and a flush.
// - Sits between SubBytes and MixColumns in the unrolled/streaming cipher datapath.
// - Accepts one beat (NumLanes states) per cycle.
// PARAMETERS
// - NumLanes   1  number of independent 128-bit states per beat, 1..8
// - PipeDepth  1  number of register stages, 1..4; PipeDepth = latency without backpressure
// PORTS
// - clk_i        in   1             clock
// - rst_i        in   1             reset: synchronous, active-high
// - flush_i      in   1             synchronous pipeline clear
// - op_i         in   2             ciph_op_e: 2'b01 CIPH_FWD, 2'b10 CIPH_INV, others treated as FWD; sampled with the beat
// - in_valid_i   in   1             input beat valid
// - in_ready_o   out  1             input beat accepted when in_valid_i && in_ready_o
// - data_i       in   128*NumLanes  lane l at [128*l +: 128]
// - out_valid_o  out  1             output beat valid
// - out_ready_i  in   1             downstream ready
// - data_o       out  128*NumLanes  permuted states, same lane layout as data_i
// - beat_cnt_o   out  32            accepted-beat counter; only meaningful with AES_SHIFT_ROWS_CNT_EN
// BEHAVIOUR
// - State layout per lane: row r = [32*r +: 32]; column c = byte [8*c +: 8] of the row.
// - FWD: out[r][c] = in[r][(c+r)%4]. INV: out[r][c] = in[r][(c-r)%4]. Row 0 is never moved; row 2 is identical for FWD and INV.
// - Permutation is combinational on data_i/op_i and is captured into stage 0; later stages only move data. op is not carried.
// - Per stage k: valid_q[k] and data_q[k]. Stage k loads when !valid_q[k] || ready[k+1], where ready[PipeDepth] = out_ready_i.
// - in_ready_o = (!valid_q[0] || ready[1]) && !flush_i. Full throughput is 1 beat/cycle under continuous out_ready_i.
// - Latency: a beat accepted in cycle t appears on out_valid_o/data_o in cycle t+PipeDepth if never stalled.
// - out_valid_o = valid_q[PipeDepth-1]; data_o = data_q[PipeDepth-1]. Beats are never dropped or duplicated.
// - Backpressure: while out_valid_o && !out_ready_i, data_o is held stable. Bubbles collapse: a full pipe with PipeDepth beats stalls in_ready_o.
// - flush_i: at the next edge all valid_q clear; data_q are held. No beat is accepted in the flush cycle.
// - flush_i together with in_valid_i: flush wins and the input beat is not accepted.
// - Reset (rst_i=1 at edge): all valid_q=0, all data_q=0, beat_cnt=0. Outputs after reset: out_valid_o=0, data_o=0, in_ready_o=1 (when flush_i=0).
// - Reset mid-stream discards all in-flight beats. rst_i has priority over flush_i.
// - Lanes are fully independent and share op_i and the handshake.
// CONFIGURATION
// - AES_SHIFT_ROWS_CNT_EN defined: a 32-bit beat counter increments on each accepted input beat.
//   - Saturates at 32'hFFFF_FFFF.
//   - Cleared by rst_i; not cleared by flush_i.
//   - Drives beat_cnt_o.
// - AES_SHIFT_ROWS_CNT_EN undefined: no counter flops; beat_cnt_o tied to 32'h0.
// STRUCTURE
// - aes_pkg provides ciph_op_e and aes_circ_byte_shift (existing).
// - Add to aes_pkg: aes_inv_shift_rows function, and localparams AES_STATE_W=128 and AES_ROW_W=32.
// - Sub-module aes_shift_rows_lane: combinational single-state FWD/INV permutation, instantiated NumLanes times.
// - Pipeline registers and handshake live in the top module, built with a generate loop over PipeDepth.
// TESTING
// - Fwd vector: NumLanes=1, op=01, data_i=128'h0f0e0d0c_0b0a0908_07060504_03020100
//   -> data_o=128'h0e0d0c0f_09080b0a_04070605_03020100 after PipeDepth cycles.
// - Inv vector: same data_i, op=10 -> data_o=128'h0c0f0e0d_09080b0a_06050407_03020100.
//   - op=00 and op=11 give the FWD result.
// - Streaming: PipeDepth=3, NumLanes=4, 100 back-to-back beats of random data and op, out_ready_i=1
//   -> 1 beat/cycle, in-order outputs matching the model, first output at cycle 3.
// - Backpressure: hold out_ready_i=0 for 10 cycles -> exactly PipeDepth beats are accepted, then in_ready_o=0.
//   - data_o stays stable; release -> no loss or duplication.
// - Flush/reset: flush_i with 2 beats in flight and in_valid_i=1 -> next cycle out_valid_o=0 and the input is not taken.
//   - rst_i mid-stream -> out_valid_o=0, data_o=0, beat_cnt_o=0.
// - Counter (AES_SHIFT_ROWS_CNT_EN): 7 accepted beats -> beat_cnt_o=7; it survives a flush.
//   - Force the counter to 32'hFFFF_FFFE then send 3 beats -> 32'hFFFF_FFFF.
//   - Without the macro, beat_cnt_o=0 always.

Source files
------------

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES datapath types and helpers.
//   ciph_op_e            : cipher direction (FWD / INV)
//   AES_STATE_W          : width of one AES state (128)
//   AES_ROW_W            : width of one state row (32)
//   aes_circ_byte_shift  : rotate a 32-bit row by whole bytes
//   aes_fwd_shift_rows   : ShiftRows on one state
//   aes_inv_shift_rows   : InvShiftRows on one state
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int unsigned AES_STATE_W = 128;
    localparam int unsigned AES_ROW_W   = 32;

    typedef enum logic [1:0] {
        CIPH_FWD = 2'b01,
        CIPH_INV = 2'b10
    } ciph_op_e;

    // Output byte c takes input byte (c - shift) mod 4.
    function automatic logic [AES_ROW_W-1:0] aes_circ_byte_shift(
        input logic [AES_ROW_W-1:0] in,
        input logic [1:0]           shift
    );
        logic [AES_ROW_W-1:0] out;
        logic [1:0]           src;
        out = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            src               = 2'(c) - shift;
            out[8*c +: 8]     = in[8*src +: 8];
        end
        return out;
    endfunction

    // Row r: out[c] = in[(c + r) mod 4], i.e. byte shift of -r.
    function automatic logic [AES_STATE_W-1:0] aes_fwd_shift_rows(
        input logic [AES_STATE_W-1:0] in
    );
        logic [AES_STATE_W-1:0] out;
        out = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            out[AES_ROW_W*r +: AES_ROW_W] =
                aes_circ_byte_shift(in[AES_ROW_W*r +: AES_ROW_W], 2'(4 - r));
        end
        return out;
    endfunction

    // Row r: out[c] = in[(c - r) mod 4], i.e. byte shift of +r.
    function automatic logic [AES_STATE_W-1:0] aes_inv_shift_rows(
        input logic [AES_STATE_W-1:0] in
    );
        logic [AES_STATE_W-1:0] out;
        out = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            out[AES_ROW_W*r +: AES_ROW_W] =
                aes_circ_byte_shift(in[AES_ROW_W*r +: AES_ROW_W], 2'(r));
        end
        return out;
    endfunction

endpackage

// File: rtl/aes_shift_rows_lane.sv
// -----------------------------------------------------------------------------
// aes_shift_rows_lane
// Combinational ShiftRows / InvShiftRows of a single 128-bit state.
//   op_i      : ciph_op_e; anything other than CIPH_INV permutes forward
//   data_i    : input state, row r at [32*r +: 32]
//   data_c_o  : permuted state (combinational)
// -----------------------------------------------------------------------------
module aes_shift_rows_lane
    import aes_pkg::*;
(
    input  logic [1:0]             op_i,
    input  logic [AES_STATE_W-1:0] data_i,
    output logic [AES_STATE_W-1:0] data_c_o
);

    // Only the explicit INV encoding selects the inverse permutation.
    always_comb begin
        data_c_o = aes_fwd_shift_rows(data_i);
        if (op_i == CIPH_INV) begin
            data_c_o = aes_inv_shift_rows(data_i);
        end
    end

endmodule

// File: rtl/aes_shift_rows_pipe.sv
// -----------------------------------------------------------------------------
// aes_shift_rows_pipe
// Pipelined multi-lane ShiftRows / InvShiftRows with valid/ready handshake.
// Optional feature macro: AES_SHIFT_ROWS_CNT_EN (accepted-beat counter).
//   clk_i        : clock
//   rst_i        : synchronous active-high reset
//   flush_i      : clears all in-flight beats, blocks input this cycle
//   op_i         : ciph_op_e, sampled with the input beat
//   in_valid_i   : input beat valid
//   in_ready_o   : input beat accepted when in_valid_i && in_ready_o
//   data_i       : NumLanes states, lane l at [128*l +: 128]
//   out_valid_o  : output beat valid
//   out_ready_i  : downstream ready
//   data_o       : permuted states, same lane layout as data_i
//   beat_cnt_o   : saturating accepted-beat count (0 without the macro)
// -----------------------------------------------------------------------------
module aes_shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int unsigned NumLanes  = 1,
    parameter int unsigned PipeDepth = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            flush_i,
    input  logic [1:0]                      op_i,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [AES_STATE_W*NumLanes-1:0] data_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [AES_STATE_W*NumLanes-1:0] data_o,
    output logic [31:0]                     beat_cnt_o
);

    localparam int unsigned DataW = AES_STATE_W * NumLanes;

    // Per-lane permutation feeding stage 0.
    logic [DataW-1:0] perm_c;

    for (genvar l = 0; l < NumLanes; l++) begin : g_lane
        aes_shift_rows_lane u_lane (
            .op_i     (op_i),
            .data_i   (data_i[AES_STATE_W*l +: AES_STATE_W]),
            .data_c_o (perm_c[AES_STATE_W*l +: AES_STATE_W])
        );
    end

    logic [PipeDepth-1:0] valid_q;
    logic [PipeDepth-1:0] valid_d;
    logic [DataW-1:0]     data_q [PipeDepth];
    logic [DataW-1:0]     data_d [PipeDepth];
    logic [PipeDepth-1:0] ready_c;
    logic [PipeDepth-1:0] load_c;

    for (genvar k = 0; k < PipeDepth; k++) begin : g_stage
        logic             src_valid;
        logic [DataW-1:0] src_data;

        if (k == 0) begin : g_head
            assign src_valid = in_valid_i;
            assign src_data  = perm_c;
        end else begin : g_body
            assign src_valid = valid_q[k-1];
            assign src_data  = data_q[k-1];
        end

        // Stage k is blocked only if it and every later stage hold a beat and
        // the sink is stalled; flattened so there is no combinational chain.
        assign ready_c[k] = ~((&valid_q[PipeDepth-1:k]) & ~out_ready_i);

        // Data only moves with a real beat so empty stages keep their contents.
        assign load_c[k]  = ready_c[k] & src_valid & ~flush_i;
        assign valid_d[k] = flush_i    ? 1'b0      :
                            ready_c[k] ? src_valid : valid_q[k];
        assign data_d[k]  = load_c[k] ? src_data : data_q[k];
    end

    // Pipeline registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int unsigned k = 0; k < PipeDepth; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int unsigned k = 0; k < PipeDepth; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign in_ready_o  = ready_c[0] & ~flush_i;
    assign out_valid_o = valid_q[PipeDepth-1];
    assign data_o      = data_q[PipeDepth-1];

`ifdef AES_SHIFT_ROWS_CNT_EN
    logic [31:0] beat_cnt_q;
    logic [31:0] beat_cnt_d;

    // Saturating count of accepted input beats; flush does not clear it.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (in_valid_i && in_ready_o && (beat_cnt_q != 32'hFFFF_FFFF)) begin
            beat_cnt_d = beat_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign beat_cnt_o = beat_cnt_q;
`else
    assign beat_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// -----------------------------------------------------------------------------
// tb_aes_shift_rows_pipe
// Scoreboard bench: the driver pushes expected beats on acceptance, a monitor
// pops and compares whenever an output beat is transferred.
// Optional feature macro: AES_SHIFT_ROWS_CNT_EN (counter checks).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_aes_shift_rows_pipe;

    localparam int unsigned NL = 4;
    localparam int unsigned PD = 3;
    localparam int unsigned DW = 128 * NL;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [1:0]    op;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] din;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] dout;
    logic [31:0]   beat_cnt;

    always #5 clk = ~clk;

    aes_shift_rows_pipe #(.NumLanes(NL), .PipeDepth(PD)) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .op_i        (op),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .data_i      (din),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .data_o      (dout),
        .beat_cnt_o  (beat_cnt)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   n_out   = 0;
    bit   lat_chk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Independent reference: row r, column c taken from column (c+r) or (c-r).
    function automatic logic [127:0] model(input logic [127:0] s, input logic [1:0] o);
        logic [127:0] r;
        r = '0;
        for (int row = 0; row < 4; row++) begin
            for (int c = 0; c < 4; c++) begin
                int src;
                src = (o == 2'b10) ? (c - row + 4) % 4 : (c + row) % 4;
                r[32*row + 8*c +: 8] = s[32*row + 8*src +: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] model_beat(input logic [DW-1:0] d, input logic [1:0] o);
        logic [DW-1:0] r;
        r = '0;
        for (int l = 0; l < NL; l++) r[128*l +: 128] = model(d[128*l +: 128], o);
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < DW / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Monitor: compares every transferred output beat against the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_out++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got %0h expected none", dout);
            end else begin
                mon_e = sb_q.pop_front();
                chk("data_o", dout, mon_e.data);
                if (lat_chk) chk("latency", DW'(cyc - mon_e.cyc), DW'(PD));
            end
        end
    end

    // Presents one beat and waits (bounded) for acceptance; leaves in_valid high.
    task automatic send(input logic [DW-1:0] d, input logic [1:0] o,
                        input logic [DW-1:0] exp, output int acc_cyc);
        int n;
        n = 0;
        acc_cyc = -1;
        @(posedge clk); #1;
        in_valid = 1'b1;
        din      = d;
        op       = o;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back('{exp, cyc});
                acc_cyc = cyc;
                break;
            end
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got no in_ready expected accept");
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk(name, DW'(sb_q.size()), DW'(0));
    endtask

    logic [127:0]  vec;
    logic [127:0]  fwd_e;
    logic [127:0]  inv_e;
    logic [DW-1:0] d;
    logic [DW-1:0] held;
    logic [1:0]    o;
    int            acc;
    int            first_acc;
    int            last_acc;
    int            n0;
    bit            held_v;
    bit            stable_bad;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        op        = 2'b00;
        in_valid  = 1'b0;
        din       = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", DW'(out_valid), DW'(0));
        chk("rst_data_o", dout, '0);
        chk("rst_in_ready", DW'(in_ready), DW'(1));
        chk("rst_beat_cnt", DW'(beat_cnt), DW'(0));

        // Directed vectors, all lanes identical, hand-computed results
        vec   = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
        fwd_e = 128'h0e0d0c0f_09080b0a_04070605_03020100;
        inv_e = 128'h0c0f0e0d_09080b0a_06050407_03020100;
        lat_chk = 1'b1;
        send({NL{vec}}, 2'b01, {NL{fwd_e}}, acc);
        send({NL{vec}}, 2'b10, {NL{inv_e}}, acc);
        send({NL{vec}}, 2'b00, {NL{fwd_e}}, acc);
        send({NL{vec}}, 2'b11, {NL{fwd_e}}, acc);
        idle();
        drain("directed_drain");

        // Streaming: 100 back-to-back random beats
        for (int i = 0; i < 100; i++) begin
            d = rand_beat();
            o = 2'($urandom_range(0, 3));
            send(d, o, model_beat(d, o), acc);
            if (i == 0) first_acc = acc;
            last_acc = acc;
        end
        idle();
        drain("stream_drain");
        chk("stream_throughput", DW'(last_acc - first_acc), DW'(99));
        lat_chk = 1'b0;

        // Backpressure: sink stalled for 10 cycles
        out_ready  = 1'b0;
        acc        = 0;
        held_v     = 1'b0;
        stable_bad = 1'b0;
        held       = '0;
        n0         = n_out;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            din      = {NL{32'hA500_0000 + 32'(acc)}};
            op       = 2'b01;
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back('{model_beat(din, 2'b01), cyc});
                acc++;
            end
            if (out_valid) begin
                if (!held_v) begin
                    held   = dout;
                    held_v = 1'b1;
                end else if (dout !== held) begin
                    stable_bad = 1'b1;
                end
            end
        end
        chk("bp_accepted", DW'(acc), DW'(PD));
        chk("bp_in_ready", DW'(in_ready), DW'(0));
        chk("bp_out_valid", DW'(out_valid), DW'(1));
        chk("bp_stable", DW'(stable_bad), DW'(0));
        chk("bp_head", held, model_beat({NL{32'hA500_0000}}, 2'b01));
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("bp_drain");
        chk("bp_out_count", DW'(n_out - n0), DW'(PD));

        // Flush with two beats in flight and a beat offered
        out_ready = 1'b0;
        d = rand_beat();
        send(d, 2'b01, model_beat(d, 2'b01), acc);
        d = rand_beat();
        send(d, 2'b10, model_beat(d, 2'b10), acc);
        @(posedge clk); #1;
        flush    = 1'b1;
        in_valid = 1'b1;
        din      = rand_beat();
        @(negedge clk);
        chk("flush_in_ready", DW'(in_ready), DW'(0));
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        sb_q.delete();
        @(negedge clk);
        chk("flush_out_valid", DW'(out_valid), DW'(0));
        out_ready = 1'b1;
        repeat (PD + 2) @(negedge clk);
        chk("flush_nothing_taken", DW'(out_valid), DW'(0));

        // Reset mid-stream
        d = rand_beat();
        send(d, 2'b01, model_beat(d, 2'b01), acc);
        d = rand_beat();
        send(d, 2'b10, model_beat(d, 2'b10), acc);
        @(posedge clk); #1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
        @(negedge clk);
        chk("midrst_out_valid", DW'(out_valid), DW'(0));
        chk("midrst_data_o", dout, '0);
        chk("midrst_beat_cnt", DW'(beat_cnt), DW'(0));
        chk("midrst_in_ready", DW'(in_ready), DW'(1));
        out_ready = 1'b1;

        // Counter: 7 beats, then a flush
        for (int i = 0; i < 7; i++) begin
            d = rand_beat();
            send(d, 2'b01, model_beat(d, 2'b01), acc);
        end
        idle();
        drain("cnt_drain");
`ifdef AES_SHIFT_ROWS_CNT_EN
        chk("cnt_seven", DW'(beat_cnt), DW'(7));
`else
        chk("cnt_tied_zero", DW'(beat_cnt), DW'(0));
`endif
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
`ifdef AES_SHIFT_ROWS_CNT_EN
        chk("cnt_after_flush", DW'(beat_cnt), DW'(7));
        @(posedge clk); #1;
        force u_dut.beat_cnt_q = 32'hFFFF_FFFE;
        #1 release u_dut.beat_cnt_q;
        for (int i = 0; i < 3; i++) begin
            d = rand_beat();
            send(d, 2'b10, model_beat(d, 2'b10), acc);
        end
        idle();
        drain("sat_drain");
        chk("cnt_saturate", DW'(beat_cnt), DW'(32'hFFFF_FFFF));
`else
        chk("cnt_zero_after_flush", DW'(beat_cnt), DW'(0));
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", DW'(sb_q.size()), DW'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
